button_reader: RTL and testbench

BUTTON_READER -- requirements
Module: button_reader

---
 rtl/button_reader_pkg.sv | 19 +
 rtl/button_reader_btn_debounce.sv | 59 +++++
 rtl/button_reader.sv | 88 ++++++++
 tb/tb_button_reader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_reader_pkg.sv
// Shared constants and types for the button reader.
// Holds default sizes, debounce counter width and the event FSM states.
package button_reader_pkg;

  localparam int N_BTN_DEF    = 8;
  localparam int DEBOUNCE_DEF = 250000;

  function automatic int cnt_width(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DEBOUNCE_DEF);

  typedef enum logic {
    IDLE,
    PENDING
  } evt_state_t;

endpackage

// File: rtl/button_reader_btn_debounce.sv
// Single-bit debouncer: 2-flop sync, invert, stable-count, edge strobes.
// Ports: clock, rst_n, sw_raw (active-low raw) -> state, press_pulse, release_pulse.
module btn_debounce
  import button_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clock,
  input  logic rst_n,
  input  logic sw_raw,
  output logic state,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Synchronizer idles at the released level so reset never looks like a press.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  assign level = ~sync2;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      cnt           <= '0;
      state         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (level == state) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt           <= '0;
        state         <= ~state;
        press_pulse   <= ~state;
        release_pulse <= state;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_reader.sv
// Debounced button reader with press/release strobes and a press-event handshake.
// Ports: clock, MSS_RESET_N, SW -> state, press_pulse, release_pulse,
//        evt_valid/evt_data/evt_ready, evt_overflow, press_count (BTN_READER_COUNT_EN).
module button_reader
  import button_reader_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic             clock,
  input  logic             MSS_RESET_N,
  input  logic [N_BTN-1:0] SW,
  output logic [N_BTN-1:0] state,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic             evt_valid,
  output logic [N_BTN-1:0] evt_data,
  input  logic             evt_ready,
`ifdef BTN_READER_COUNT_EN
  output logic             evt_overflow,
  output logic [7:0]       press_count
`else
  output logic             evt_overflow
`endif
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clock        (clock),
      .rst_n        (MSS_RESET_N),
      .sw_raw       (SW[i]),
      .state        (state[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i])
    );
  end

  evt_state_t st;
  logic       any_press;

  assign any_press = |press_pulse;
  assign evt_valid = (st == PENDING);

  always_ff @(posedge clock) begin
    if (!MSS_RESET_N) begin
      st           <= IDLE;
      evt_data     <= '0;
      evt_overflow <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (any_press) begin
            evt_data <= press_pulse;
            st       <= PENDING;
          end
        end
        PENDING: begin
          if (evt_ready) begin
            if (any_press) evt_data <= press_pulse;
            else           st       <= IDLE;
          end else if (any_press) begin
            // Consumer is late: fold new presses in and flag the loss.
            evt_data     <= evt_data | press_pulse;
            evt_overflow <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

`ifdef BTN_READER_COUNT_EN
  logic [7:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_BTN; i++) pop = pop + 8'(press_pulse[i]);
  end

  always_ff @(posedge clock) begin
    if (!MSS_RESET_N) press_count <= '0;
    else              press_count <= press_count + pop;
  end
`endif

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with DEBOUNCE_CYCLES=4, N_BTN=8.
// Covers reset, glitch, press latency, merge/overflow, same-cycle accept, resets.
module tb_button_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw;
  logic [7:0] state;
  logic [7:0] press_pulse;
  logic [7:0] release_pulse;
  logic       evt_valid;
  logic [7:0] evt_data;
  logic       evt_ready;
  logic       evt_overflow;
`ifdef BTN_READER_COUNT_EN
  logic [7:0] press_count;
`endif

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  button_reader #(
    .N_BTN(8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock        (clk),
    .MSS_RESET_N  (rst_n),
    .SW           (sw),
    .state        (state),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .evt_valid    (evt_valid),
    .evt_data     (evt_data),
    .evt_ready    (evt_ready),
`ifdef BTN_READER_COUNT_EN
    .evt_overflow (evt_overflow),
    .press_count  (press_count)
`else
    .evt_overflow (evt_overflow)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    sw = 8'hFF;
    evt_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (state !== 8'h00 || press_pulse !== 8'h00 ||
          release_pulse !== 8'h00 || evt_valid !== 1'b0) begin
        $display("FAIL reset_idle cyc=%0d got st=%h pp=%h rp=%h v=%b exp 00 00 00 0",
                 c, state, press_pulse, release_pulse, evt_valid);
        errs++;
      end
    end
    checks++;
    if (evt_overflow !== 1'b0 || evt_data !== 8'h00) begin
      $display("FAIL reset_evt got ovf=%b data=%h exp 0 00", evt_overflow, evt_data);
      errs++;
    end
  endtask

  task automatic test_glitch;
    sw[3] = 1'b0;
    repeat (3) tick();
    sw[3] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (state !== 8'h00 || press_pulse !== 8'h00 || evt_valid !== 1'b0) begin
        $display("FAIL glitch cyc=%0d got st=%h pp=%h v=%b exp 00 00 0",
                 c, state, press_pulse, evt_valid);
        errs++;
      end
    end
  endtask

  task automatic test_press;
    sw[0] = 1'b0;
    repeat (5) tick();
    checks++;
    if (state !== 8'h00) begin
      $display("FAIL press_early got=%h exp=%h", state, 8'h00);
      errs++;
    end
    tick();
    checks++;
    if (state !== 8'h01 || press_pulse !== 8'h01) begin
      $display("FAIL press_edge got st=%h pp=%h exp 01 01", state, press_pulse);
      errs++;
    end
    tick();
    checks++;
    if (press_pulse !== 8'h00 || evt_valid !== 1'b1 || evt_data !== 8'h01) begin
      $display("FAIL press_evt got pp=%h v=%b d=%h exp 00 1 01",
               press_pulse, evt_valid, evt_data);
      errs++;
    end
  endtask

  task automatic test_overflow;
    sw[5] = 1'b0;
    repeat (6) tick();
    checks++;
    if (press_pulse !== 8'h20 || evt_data !== 8'h01 || evt_overflow !== 1'b0) begin
      $display("FAIL ovf_pre got pp=%h d=%h o=%b exp 20 01 0",
               press_pulse, evt_data, evt_overflow);
      errs++;
    end
    tick();
    checks++;
    if (evt_data !== 8'h21 || evt_overflow !== 1'b1 || evt_valid !== 1'b1) begin
      $display("FAIL ovf_merge got d=%h o=%b v=%b exp 21 1 1",
               evt_data, evt_overflow, evt_valid);
      errs++;
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checks++;
    if (evt_valid !== 1'b0 || evt_data !== 8'h21 || evt_overflow !== 1'b1) begin
      $display("FAIL ovf_accept got v=%b d=%h o=%b exp 0 21 1",
               evt_valid, evt_data, evt_overflow);
      errs++;
    end
    sw[0] = 1'b1;
    sw[5] = 1'b1;
    repeat (6) tick();
    checks++;
    if (release_pulse !== 8'h21 || state !== 8'h00 || press_pulse !== 8'h00) begin
      $display("FAIL release got rp=%h st=%h pp=%h exp 21 00 00",
               release_pulse, state, press_pulse);
      errs++;
    end
    tick();
    checks++;
    if (evt_valid !== 1'b0 || release_pulse !== 8'h00) begin
      $display("FAIL release_noevt got v=%b rp=%h exp 0 00", evt_valid, release_pulse);
      errs++;
    end
  endtask

  task automatic test_same_cycle;
    sw = 8'hFF;
    do_reset();
    sw[0] = 1'b0;
    repeat (7) tick();
    sw[7] = 1'b0;
    repeat (6) tick();
    checks++;
    if (press_pulse !== 8'h80 || evt_data !== 8'h01 || evt_valid !== 1'b1) begin
      $display("FAIL same_pre got pp=%h d=%h v=%b exp 80 01 1",
               press_pulse, evt_data, evt_valid);
      errs++;
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checks++;
    if (evt_data !== 8'h80 || evt_valid !== 1'b1 || evt_overflow !== 1'b0) begin
      $display("FAIL same_cycle got d=%h v=%b o=%b exp 80 1 0",
               evt_data, evt_valid, evt_overflow);
      errs++;
    end
    tick();
    checks++;
    if (evt_data !== 8'h80 || evt_valid !== 1'b1) begin
      $display("FAIL hold got d=%h v=%b exp 80 1", evt_data, evt_valid);
      errs++;
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checks++;
    if (evt_valid !== 1'b0 || evt_data !== 8'h80) begin
      $display("FAIL accept_idle got v=%b d=%h exp 0 80", evt_valid, evt_data);
      errs++;
    end
  endtask

  task automatic test_mid_reset;
    sw = 8'hFF;
    do_reset();
    sw[2] = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (state !== 8'h00 || press_pulse !== 8'h00 || release_pulse !== 8'h00 ||
        evt_valid !== 1'b0 || evt_data !== 8'h00 || evt_overflow !== 1'b0) begin
      $display("FAIL midrst_clear got st=%h pp=%h rp=%h v=%b d=%h o=%b exp all 0",
               state, press_pulse, release_pulse, evt_valid, evt_data, evt_overflow);
      errs++;
    end
    repeat (5) tick();
    checks++;
    if (state !== 8'h00) begin
      $display("FAIL midrst_discard got=%h exp=%h", state, 8'h00);
      errs++;
    end
    tick();
    checks++;
    if (state !== 8'h04 || press_pulse !== 8'h04) begin
      $display("FAIL midrst_restart got st=%h pp=%h exp 04 04", state, press_pulse);
      errs++;
    end
  endtask

`ifdef BTN_READER_COUNT_EN
  task automatic test_count;
    sw = 8'hFF;
    do_reset();
    checks++;
    if (press_count !== 8'd0) begin
      $display("FAIL count_reset got=%0d exp=0", press_count);
      errs++;
    end
    for (int n = 0; n < 300; n++) begin
      sw[1] = 1'b0;
      repeat (6) tick();
      sw[1] = 1'b1;
      repeat (6) tick();
    end
    checks++;
    if (press_count !== 8'd44) begin
      $display("FAIL count_wrap got=%0d exp=44", press_count);
      errs++;
    end
    sw[1] = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (press_count !== 8'd0 || state !== 8'h00 || evt_valid !== 1'b0 ||
        evt_overflow !== 1'b0 || evt_data !== 8'h00) begin
      $display("FAIL count_rst got cnt=%0d st=%h v=%b o=%b d=%h exp all 0",
               press_count, state, evt_valid, evt_overflow, evt_data);
      errs++;
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    sw = 8'hFF;
    evt_ready = 1'b0;
    test_reset();
    test_glitch();
    test_press();
    test_overflow();
    test_same_cycle();
    test_mid_reset();
`ifdef BTN_READER_COUNT_EN
    test_count();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
